// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared CPU header slice for the HI/LO multiply/divide unit.
// Holds the opcodes, FSM state encodings and the default iteration count.
package muldiv_hilo_ctrl_pkg;

    localparam int WORD_W       = 32;
    localparam int ALU_OP_W     = 6;
    localparam int ITER_CNT_DEF = 32;

    typedef logic [ALU_OP_W-1:0] alu_op_t;
    typedef logic [WORD_W-1:0]   word_t;

    localparam alu_op_t INSN_MTHI  = 6'h11;
    localparam alu_op_t INSN_MTLO  = 6'h13;
    localparam alu_op_t INSN_MULT  = 6'h18;
    localparam alu_op_t INSN_MULTU = 6'h19;
    localparam alu_op_t INSN_DIV   = 6'h1a;
    localparam alu_op_t INSN_DIVU  = 6'h1b;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Per-operation context captured when a multiply/divide is accepted.
    typedef struct packed {
        logic is_div;
        logic neg_res;
        logic neg_rem;
        logic div0;
    } md_ctx_t;

    function automatic logic is_md_op(alu_op_t op);
        return (op == INSN_MULT) || (op == INSN_MULTU) ||
               (op == INSN_DIV)  || (op == INSN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage / write-back handshake bundle for the HI/LO multiply/divide unit.
interface muldiv_hilo_ctrl_if;
    import muldiv_hilo_ctrl_pkg::*;

    logic    flush;
    logic    req_valid;
    alu_op_t req_op;
    word_t   scr0_data;
    word_t   scr1_data;
    logic    wb_allin;
    logic    md_ready;
    logic    md_busy;
    logic    md_done;
    word_t   hi;
    word_t   lo;

    modport master (
        output flush, req_valid, req_op, scr0_data, scr1_data, wb_allin,
        input  md_ready, md_busy, md_done, hi, lo
    );

    modport slave (
        input  flush, req_valid, req_op, scr0_data, scr1_data, wb_allin,
        output md_ready, md_busy, md_done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter.sv
// Shared radix-2 iteration engine: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per cycle, with its own step counter.
module muldiv_iter
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int ITER_CNT = ITER_CNT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  mode_div,
    input  word_t                 op_a,
    input  word_t                 op_b,
    output logic                  last_step,
    output logic [2*WORD_W-1:0]   result
);

    localparam int CNT_W = $clog2(ITER_CNT + 1);

    // Multiply: acc = {partial(33), multiplier}. Divide: acc = {rem(33), quotient}.
    logic [2*WORD_W:0] acc;
    word_t             opnd;
    logic [CNT_W-1:0]  cnt;
    logic              div_mode;

    logic [WORD_W:0]   mul_sum;
    logic [2*WORD_W:0] mul_next;
    logic [WORD_W:0]   rem_sh;
    logic [WORD_W+1:0] trial;
    logic [2*WORD_W:0] div_next;

    always_comb begin
        mul_sum  = acc[2*WORD_W:WORD_W] + {1'b0, (acc[0] ? opnd : '0)};
        mul_next = {1'b0, mul_sum, acc[WORD_W-1:1]};
        rem_sh   = acc[2*WORD_W-1:WORD_W-1];
        trial    = {1'b0, rem_sh} - {2'b00, opnd};
        if (trial[WORD_W+1]) begin
            div_next = {rem_sh, acc[WORD_W-2:0], 1'b0};
        end else begin
            div_next = {trial[WORD_W:0], acc[WORD_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{(WORD_W+1){1'b0}}, (mode_div ? op_a : op_b)};
            opnd     <= mode_div ? op_b : op_a;
            cnt      <= '0;
            div_mode <= mode_div;
        end else if (step) begin
            acc <= div_mode ? div_next : mul_next;
            cnt <= cnt + 1'b1;
        end
    end

    assign last_step = step && (cnt == CNT_W'(ITER_CNT - 1));
    assign result    = acc[2*WORD_W-1:0];

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO multiply/divide controller: request decode, IDLE/CALC/FIX/DONE FSM,
// sign correction and the architectural HI/LO registers.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int ITER_CNT = ITER_CNT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_hilo_ctrl_if.slave bus
);

    logic [1:0]              state;
    md_ctx_t                 ctx;
    word_t                   hi_q;
    word_t                   lo_q;
    word_t                   res_hi;
    word_t                   res_lo;

    logic                    accept;
    logic                    accept_md;
    logic                    op_signed;
    logic                    op_div;
    logic                    neg_a;
    logic                    neg_b;
    logic signed [WORD_W-1:0] src_a_s;
    logic signed [WORD_W-1:0] src_b_s;
    word_t                   mag_a;
    word_t                   mag_b;
    logic                    iter_step;
    logic                    iter_last;
    logic [2*WORD_W-1:0]     iter_res;

    function automatic word_t cond_neg32(word_t v, logic en);
        return en ? (~v + word_t'(1)) : v;
    endfunction

    function automatic logic [2*WORD_W-1:0] cond_neg64(logic [2*WORD_W-1:0] v, logic en);
        return en ? (~v + {{(2*WORD_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign accept    = bus.req_valid && (state == ST_IDLE) && !bus.flush;
    assign accept_md = accept && is_md_op(bus.req_op);
    assign op_signed = (bus.req_op == INSN_MULT) || (bus.req_op == INSN_DIV);
    assign op_div    = (bus.req_op == INSN_DIV)  || (bus.req_op == INSN_DIVU);

    // The engine only works on magnitudes; signs are reapplied in FIX.
    assign src_a_s = $signed(bus.scr0_data);
    assign src_b_s = $signed(bus.scr1_data);
    assign neg_a   = op_signed && (src_a_s < 0);
    assign neg_b   = op_signed && (src_b_s < 0);
    assign mag_a   = cond_neg32(bus.scr0_data, neg_a);
    assign mag_b   = cond_neg32(bus.scr1_data, neg_b);

    assign iter_step = (state == ST_CALC);

    muldiv_iter #(
        .ITER_CNT (ITER_CNT)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_md),
        .step      (iter_step),
        .mode_div  (op_div),
        .op_a      (mag_a),
        .op_b      (mag_b),
        .last_step (iter_last),
        .result    (iter_res)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ctx    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_md) begin
                        ctx.is_div  <= op_div;
                        ctx.neg_res <= neg_a ^ neg_b;
                        ctx.neg_rem <= neg_a;
                        ctx.div0    <= (bus.scr1_data == '0);
                        state       <= ST_CALC;
                    end else if (accept && (bus.req_op == INSN_MTHI)) begin
                        hi_q <= bus.scr0_data;
                    end else if (accept && (bus.req_op == INSN_MTLO)) begin
                        lo_q <= bus.scr0_data;
                    end
                end
                ST_CALC: begin
                    if (iter_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Divide by zero leaves rem = |dividend|, so the remainder fix restores the dividend.
                    if (ctx.is_div) begin
                        res_hi <= cond_neg32(iter_res[2*WORD_W-1:WORD_W], ctx.neg_rem);
                        res_lo <= ctx.div0 ? '1 : cond_neg32(iter_res[WORD_W-1:0], ctx.neg_res);
                    end else begin
                        {res_hi, res_lo} <= cond_neg64(iter_res, ctx.neg_res);
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.wb_allin) begin
                        hi_q  <= res_hi;
                        lo_q  <= res_lo;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.md_ready = (state == ST_IDLE);
    assign bus.md_busy  = (state != ST_IDLE);
    assign bus.md_done  = (state == ST_DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized self-checking bench for muldiv_hilo_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    word_t hi_m = '0;
    word_t lo_m = '0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl_if bus();

    muldiv_hilo_ctrl #(
        .ITER_CNT (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of one operation on HI/LO.
    task automatic ref_op(input alu_op_t op, input word_t a, input word_t b,
                          inout word_t h, inout word_t l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            INSN_MULT: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            INSN_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            INSN_DIV: begin
                if (b == 0) begin
                    l = 32'hffff_ffff;
                    h = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            INSN_DIVU: begin
                if (b == 0) begin
                    l = 32'hffff_ffff;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            INSN_MTHI: h = a;
            INSN_MTLO: l = a;
            default: ;
        endcase
    endtask

    // Called on a falling edge while idle. flush_at>0: flush in that cycle;
    // flush_at<0: flush together with wb_allin in DONE.
    task automatic run_md(input alu_op_t op, input word_t a, input word_t b,
                          input int stall, input int flush_at, input bit busy_mt);
        word_t eh, el;
        int n;
        eh = hi_m;
        el = lo_m;
        ref_op(op, a, b, eh, el);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.scr0_data = a;
        bus.scr1_data = b;
        bus.wb_allin  = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        n = 1;
        bus.req_valid = 1'b0;
        check("busy_c1", bus.md_busy, 1);
        if (flush_at > 0) begin
            while (n < flush_at) begin
                @(negedge clk);
                n++;
            end
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            check("flush_ready", bus.md_ready, 1);
            check("flush_hi", bus.hi, hi_m);
            check("flush_lo", bus.lo, lo_m);
            return;
        end
        while (!bus.md_done && n < 100) begin
            if (busy_mt && n >= 5 && n < 8) begin
                bus.req_valid = 1'b1;
                bus.req_op    = INSN_MTHI;
                bus.scr0_data = 32'h1234_5678;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        check("latency", n, 34);
        if (!bus.md_done) return;
        for (int i = 0; i < stall; i++) begin
            check("stall_done", bus.md_done, 1);
            check("stall_hi", bus.hi, hi_m);
            check("stall_lo", bus.lo, lo_m);
            @(negedge clk);
        end
        if (flush_at < 0) begin
            bus.wb_allin = 1'b1;
            bus.flush    = 1'b1;
            @(negedge clk);
            bus.wb_allin = 1'b0;
            bus.flush    = 1'b0;
            check("done_flush_ready", bus.md_ready, 1);
            check("done_flush_hi", bus.hi, hi_m);
            check("done_flush_lo", bus.lo, lo_m);
            return;
        end
        check("wb_done", bus.md_done, 1);
        bus.wb_allin = 1'b1;
        @(negedge clk);
        bus.wb_allin = 1'b0;
        hi_m = eh;
        lo_m = el;
        check("res_hi", bus.hi, hi_m);
        check("res_lo", bus.lo, lo_m);
        check("res_ready", bus.md_ready, 1);
    endtask

    task automatic mt(input alu_op_t op, input word_t a, input bit fl);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.scr0_data = a;
        bus.flush     = fl;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        if (!fl) ref_op(op, a, '0, hi_m, lo_m);
        check("mt_busy", bus.md_busy, 0);
        check("mt_hi", bus.hi, hi_m);
        check("mt_lo", bus.lo, lo_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.scr0_data = '0;
        bus.scr1_data = '0;
        bus.wb_allin  = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.md_ready, 1);
        check("rst_busy", bus.md_busy, 0);
        check("rst_done", bus.md_done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        reset = 1'b1;
        @(negedge clk);

        run_md(INSN_MULTU, 32'hffff_ffff, 32'hffff_ffff, 0, 0, 1'b0);
        run_md(INSN_MULT,  32'hffff_fffd, 32'h0000_0005, 0, 0, 1'b0);
        run_md(INSN_DIV,   32'hffff_fff9, 32'h0000_0002, 0, 0, 1'b0);
        run_md(INSN_DIVU,  32'h0000_0007, 32'h0000_0000, 0, 0, 1'b0);
        run_md(INSN_DIV,   32'h8000_0000, 32'hffff_ffff, 0, 0, 1'b0);
        run_md(INSN_DIV,   32'hffff_fff3, 32'h0000_0000, 0, 0, 1'b0);
        run_md(INSN_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);

        // Write-back stall, then mid-flight flush.
        run_md(INSN_MULT, 32'h0000_1234, 32'hffff_5678, 3, 0, 1'b0);
        run_md(INSN_MULT, 32'h0000_0007, 32'h0000_0009, 0, 10, 1'b0);

        // MTHI while busy is dropped; the same MTHI in IDLE lands.
        run_md(INSN_DIVU, 32'd100, 32'd7, 0, 0, 1'b1);
        check("busy_mthi_ignored", bus.hi, 32'd2);
        mt(INSN_MTHI, 32'h1234_5678, 1'b0);
        check("mthi_idle", bus.hi, 32'h1234_5678);

        // Flush beats a request and a DONE write-back.
        mt(INSN_MTLO, 32'hdead_beef, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_op    = INSN_MULT;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_req_ready", bus.md_ready, 1);
        run_md(INSN_DIV, 32'h0000_0063, 32'hffff_fffb, 1, -1, 1'b0);

        // Unknown opcode is ignored.
        bus.req_valid = 1'b1;
        bus.req_op    = 6'h00;
        bus.scr0_data = 32'h5555_aaaa;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("badop_busy", bus.md_busy, 0);
        check("badop_hi", bus.hi, hi_m);
        check("badop_lo", bus.lo, lo_m);

        // Reset mid-operation outranks flush and wb_allin.
        bus.req_valid = 1'b1;
        bus.req_op    = INSN_MULTU;
        bus.scr0_data = 32'h0000_0101;
        bus.scr1_data = 32'h0000_0202;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset        = 1'b0;
        bus.flush    = 1'b1;
        bus.wb_allin = 1'b1;
        @(negedge clk);
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.wb_allin = 1'b0;
        hi_m = '0;
        lo_m = '0;
        check("midrst_ready", bus.md_ready, 1);
        check("midrst_busy", bus.md_busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);

        for (int k = 0; k < 40; k++) begin
            int    kind;
            word_t a, b;
            kind = int'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'hffff_ffff;
            case (kind)
                0: run_md(INSN_MULT,  a, b, int'($urandom_range(0, 2)), 0, 1'b0);
                1: run_md(INSN_MULTU, a, b, int'($urandom_range(0, 2)), 0, 1'b0);
                2: run_md(INSN_DIV,   a, b, int'($urandom_range(0, 2)), 0, 1'b0);
                3: run_md(INSN_DIVU,  a, b, int'($urandom_range(0, 2)), 0, 1'b0);
                4: mt(INSN_MTHI, a, 1'b0);
                default: mt(INSN_MTLO, a, 1'b0);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
MULDIV_HILO_CTRL -- requirements
Module: muldiv_hilo_ctrl

Interface
REQ-001 Parameter: ITER_CNT, default 32, number of iteration cycles per multiply or divide.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 flush  in  1  synchronous pipeline flush; active high.
REQ-005 req_valid  in  1  EX stage presents a HI/LO operation this cycle.
REQ-006 req_op  in  `AluOpBus  operation code; decoded values are INSN_MULT, INSN_MULTU, INSN_DIV, INSN_DIVU, INSN_MTHI, INSN_MTLO; all others are ignored.
REQ-007 scr0_data  in  `WordDataBus  multiplicand/dividend, or MTHI/MTLO source.
REQ-008 scr1_data  in  `WordDataBus  multiplier/divisor.
REQ-009 wb_allin  in  1  write-back stage accepts a result this cycle.
REQ-010 md_ready  out  1  controller can accept a request (state IDLE).
REQ-011 md_busy  out  1  multi-cycle operation in flight; EX stage stalls on it.
REQ-012 md_done  out  1  result held in DONE, waiting for wb_allin.
REQ-013 hi  out  `WordDataBus  architectural HI register.
REQ-014 lo  out  `WordDataBus  architectural LO register.

Function
REQ-015 FSM states: IDLE, CALC, FIX, DONE. md_ready = (state==IDLE). md_busy = (state!=IDLE). md_done = (state==DONE).
REQ-016 A request is accepted only on a cycle with req_valid=1, md_ready=1, flush=0 and a decoded req_op.
REQ-017 MTHI/MTLO: on the accepting edge, hi (or lo) <= scr0_data; state stays IDLE; md_busy is never asserted.
REQ-018 MULT/DIV accept: latch |operands| (signed ops) or raw operands (unsigned ops), the result-sign flags and the op; clear the iteration counter; go to CALC.
REQ-019 CALC: one radix-2 step per cycle (shift-add multiply or restoring divide); after exactly ITER_CNT cycles go to FIX.
REQ-020 FIX: one cycle of sign correction. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend. Then go to DONE.
REQ-021 Latency: the accept cycle is C0. CALC occupies C1..C32, FIX is C33, md_done=1 from C34.
REQ-022 DONE: hold the result while wb_allin=0. On the edge where wb_allin=1, write hi <= upper product or remainder, and lo <= lower product or quotient. Go to IDLE.
REQ-023 Divide by zero: no exception; lo=0xFFFFFFFF, hi=scr0_data (as latched), for both DIV and DIVU.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no exception.
REQ-025 Multiply results are full 64-bit, modulo 2^64; the internal accumulator is 65 bits to hold the carry.
REQ-026 Flush in any state: next state IDLE; the in-flight result is discarded; hi/lo are unchanged.
REQ-027 Flush coinciding with DONE and wb_allin=1: flush wins; hi/lo are not written.
REQ-028 Flush coinciding with a request: the request is not accepted, and an MTHI/MTLO on that cycle does not write.
REQ-029 req_valid while md_busy=1: ignored; the requester holds the request until md_ready=1.

Reset
REQ-030 While reset=0 at a clock edge: state <= IDLE, hi <= 0, lo <= 0, and the counter and operand/accumulator registers are cleared.
REQ-031 After reset: md_ready=1, md_busy=0, md_done=0.
REQ-032 Reset asserted mid-operation: the operation is aborted with no hi/lo write; reset has priority over flush and wb_allin.

Structure
REQ-033 The FSM state encodings and ITER_CNT default live in the shared CPU header alongside the INSN_* opcodes; the module defines no local opcode values.
REQ-034 A single sub-module, muldiv_iter, holds the shared shift register, adder/subtractor and counter, and receives step/load/mode controls. The FSM, sign handling and HI/LO registers stay in muldiv_hilo_ctrl.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF, wb_allin=1 -> md_done in C34; hi=0xFFFFFFFE, lo=0x00000001 after C34.
REQ-036 MULT 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU 0x00000007 / 0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 MULT accepted, flush in C10 -> state IDLE in C11 with md_ready=1; hi/lo keep their pre-request values.
REQ-039 Stall and write-back ordering:
- wb_allin=0 for C34..C36, then 1 in C37 -> md_done held for 4 cycles; hi/lo update only on the C37 edge.
- MTHI 0x12345678 sent while busy is ignored; the same MTHI sent in IDLE -> hi=0x12345678 one edge later with no busy cycle.
